// File: rtl/ddrif_hzz.sv
// DLA-side DDR initiator: turns one read/write burst request into HZZ2UI command/data words and consumes UI2HZZ read data / write acks.
// Latency: command word pushed the cycle after acceptance, data beats from the following cycle; done pulses one cycle after the last pop.
// Backpressure: h2u_wfull stalls command/data pushes with no loss; u2h_rempty or rdata_ready low stalls pops; one transaction outstanding.
module ddrif_hzz #(
  parameter int HZZ_DW = 256,
  parameter int AW     = 29
) (
  input  logic              hzz_clk,
  input  logic              hzz_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [AW-1:0]     req_addr,
  input  logic [7:0]        req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [HZZ_DW-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [HZZ_DW-1:0] rdata,
  output logic              wr_done,
  output logic              rd_done,
  output logic              resp_err,
  output logic              busy,
  output logic [HZZ_DW-1:0] h2u_wdata,
  output logic              h2u_wen,
  input  logic              h2u_wfull,
  input  logic [HZZ_DW-1:0] u2h_rdata,
  output logic              u2h_ren,
  input  logic              u2h_rempty
);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, WACK, RDATA} state_t;

  state_t              state;
  logic [7:0]          cnt;
  logic [HZZ_DW-1:0]   cmd_q;
  logic [HZZ_DW-1:0]   cmd_next;

  // Command word assembled from the live request; only captured on acceptance.
  always_comb begin
    cmd_next                = '0;
    cmd_next[HZZ_DW-1]      = req_wr;
    cmd_next[HZZ_DW-3 -: 8] = req_len;
    cmd_next[AW-1:0]        = req_addr;
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rdata     = u2h_rdata;

  // FIFO/client handshakes decoded from state and FIFO flags; all idle outside their own state.
  always_comb begin
    h2u_wdata   = cmd_q;
    h2u_wen     = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    u2h_ren     = 1'b0;
    case (state)
      CMD: begin
        h2u_wen = ~h2u_wfull;
      end
      WDATA: begin
        h2u_wdata   = wdata;
        wdata_ready = ~h2u_wfull;
        h2u_wen     = wdata_valid & ~h2u_wfull;
      end
      WACK: begin
        u2h_ren = ~u2h_rempty;
      end
      RDATA: begin
        rdata_valid = ~u2h_rempty;
        u2h_ren     = ~u2h_rempty & rdata_ready;
      end
      default: begin
      end
    endcase
  end

  // Transaction FSM: beat counting, command capture, done pulses and sticky error flag.
  always_ff @(posedge hzz_clk or negedge hzz_rst_n) begin
    if (!hzz_rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      cmd_q    <= '0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd_q <= cmd_next;
            cnt   <= req_len;
            state <= CMD;
          end
        end
        CMD: begin
          if (h2u_wen) state <= cmd_q[HZZ_DW-1] ? WDATA : RDATA;
        end
        WDATA: begin
          if (h2u_wen) begin
            // cnt wraps to 0xFF on the last beat; it is reloaded on the next request.
            cnt <= cnt - 8'd1;
            if (cnt == 8'd0) state <= WACK;
          end
        end
        WACK: begin
          if (u2h_ren) begin
            state   <= IDLE;
            wr_done <= 1'b1;
            // Anything other than all-ones is a bad completion; the write still finishes.
            if (u2h_rdata != {HZZ_DW{1'b1}}) resp_err <= 1'b1;
          end
        end
        RDATA: begin
          if (u2h_ren) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd0) begin
              state   <= IDLE;
              rd_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddrif_hzz.sv
// Bench for ddrif_hzz: models both FIFOs with queues, drives directed and randomized transactions,
// and compares the pushed word stream, delivered read data and completion flags against expectations
// built from the command-word format and burst lengths.
module tb_ddrif_hzz;

  localparam int DW = 256;
  localparam int AW = 29;

  logic          hzz_clk, hzz_rst_n;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, rdata_ready;
  logic [DW-1:0] rdata;
  logic          wr_done, rd_done, resp_err, busy;
  logic [DW-1:0] h2u_wdata;
  logic          h2u_wen, h2u_wfull;
  logic [DW-1:0] u2h_rdata;
  logic          u2h_ren, u2h_rempty;

  ddrif_hzz #(.HZZ_DW(DW), .AW(AW)) dut (
    .hzz_clk(hzz_clk), .hzz_rst_n(hzz_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .wr_done(wr_done), .rd_done(rd_done), .resp_err(resp_err), .busy(busy),
    .h2u_wdata(h2u_wdata), .h2u_wen(h2u_wen), .h2u_wfull(h2u_wfull),
    .u2h_rdata(u2h_rdata), .u2h_ren(u2h_ren), .u2h_rempty(u2h_rempty)
  );

  initial hzz_clk = 1'b0;
  always #5 hzz_clk = ~hzz_clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] h2u_got[$];
  logic [DW-1:0] u2h_q[$];
  int  n_wr_done = 0;
  int  n_rd_done = 0;
  bit  acc, wfire, rfire, wfull_s, wrdy_s, wrd_s;
  logic [DW-1:0] rdata_s;
  logic [DW-1:0] ones;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] cmdw(input bit wr, input logic [7:0] len, input logic [AW-1:0] addr);
    return {wr, 1'b0, len, 246'b0} | {227'b0, addr};
  endfunction

  function automatic logic [DW-1:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic u2h_sync();
    u2h_rempty = (u2h_q.size() == 0);
    u2h_rdata  = (u2h_q.size() != 0) ? u2h_q[0] : '0;
  endtask

  task automatic u2h_push(input logic [DW-1:0] w);
    u2h_q.push_back(w);
    u2h_sync();
  endtask

  // One clock: sample handshakes just before the edge, apply FIFO effects, return at the next negedge.
  task automatic step();
    logic [DW-1:0] tmp;
    #1;
    acc     = req_valid & req_ready;
    wfire   = wdata_valid & wdata_ready;
    rfire   = rdata_valid & rdata_ready;
    wfull_s = h2u_wfull;
    wrdy_s  = wdata_ready;
    wrd_s   = wr_done;
    rdata_s = rdata;
    if (wr_done) n_wr_done++;
    if (rd_done) n_rd_done++;
    if (h2u_wen) h2u_got.push_back(h2u_wdata);
    if (u2h_ren && u2h_q.size() != 0) tmp = u2h_q.pop_front();
    @(negedge hzz_clk);
    u2h_sync();
  endtask

  task automatic accept(input bit wr, input logic [AW-1:0] addr, input logic [7:0] len);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_len = len;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc) break;
    end
    req_valid = 1'b0;
    chk("accept", acc, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len, input bit toggle,
                          input logic [DW-1:0] fixed, input logic [DW-1:0] ack,
                          input bit chain, input logic [AW-1:0] raddr);
    logic [DW-1:0] beats[$];
    int b, n0;
    for (int i = 0; i <= len; i++) beats.push_back(fixed != '0 ? fixed : rand256());
    h2u_got.delete();
    n0 = n_wr_done;
    accept(1'b1, addr, len);
    if (chain) begin
      req_valid = 1'b1; req_wr = 1'b0; req_addr = raddr; req_len = 8'd0;
    end
    b = 0;
    for (int i = 0; i < 300 && b <= len; i++) begin
      if (toggle) h2u_wfull = ~h2u_wfull;
      wdata_valid = 1'b1;
      wdata = beats[b];
      step();
      if (wfull_s) chk("wrdy_when_full", wrdy_s, 0);
      if (wfire) b++;
    end
    wdata_valid = 1'b0;
    h2u_wfull = 1'b0;
    chk("wr_beats", b, len + 1);
    u2h_push(ack);
    for (int i = 0; i < 20; i++) begin
      step();
      if (wrd_s) begin
        if (chain) chk("b2b_accept_on_done", acc, 1);
        break;
      end
    end
    req_valid = 1'b0;
    step();
    chk("wr_done_once", n_wr_done - n0, 1);
    chk("h2u_count", h2u_got.size(), len + 2 + int'(chain));
    for (int i = 0; i < len + 2 && i < h2u_got.size(); i++)
      chk("h2u_word", h2u_got[i], (i == 0) ? cmdw(1'b1, len, addr) : beats[i-1]);
    if (chain && h2u_got.size() == len + 3)
      chk("b2b_rd_cmd", h2u_got[len+2], cmdw(1'b0, 8'd0, raddr));
  endtask

  task automatic rd_phase(input logic [7:0] len, input int extra, input bit throttle);
    logic [DW-1:0] base;
    int k, n0;
    base = rand256();
    n0 = n_rd_done;
    for (int i = 0; i <= len + extra; i++) u2h_push(base + DW'(i));
    k = 0;
    for (int i = 0; i < 600 && k <= len; i++) begin
      rdata_ready = throttle ? 1'($urandom % 2) : 1'b1;
      step();
      if (rfire) begin
        chk("rd_word", rdata_s, base + DW'(k));
        k++;
      end
    end
    rdata_ready = 1'b0;
    chk("rd_beats", k, len + 1);
    for (int i = 0; i < 10 && n_rd_done == n0; i++) step();
    repeat (3) step();
    chk("rd_done_once", n_rd_done - n0, 1);
    chk("rd_left_in_fifo", u2h_q.size(), extra);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input int extra);
    logic [DW-1:0] c;
    h2u_got.delete();
    accept(1'b0, addr, len);
    rd_phase(len, extra, 1'b1);
    chk("rd_cmd_count", h2u_got.size(), 1);
    c = (h2u_got.size() != 0) ? h2u_got[0] : '0;
    chk("rd_cmd_word", c, cmdw(1'b0, len, addr));
    chk("rd_cmd_wrbit", c[DW-1], 0);
    chk("rd_cmd_len", c[DW-3 -: 8], len);
  endtask

  initial begin
    int b;
    ones = '1;
    hzz_rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    h2u_wfull = 1'b0;
    u2h_sync();
    repeat (2) @(negedge hzz_clk);

    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_h2u_wen", h2u_wen, 0);
    chk("rst_u2h_ren", u2h_ren, 0);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_resp_err", resp_err, 0);
    hzz_rst_n = 1'b1;
    step();

    // Single-beat write with all-ones ack; IDLE must not pop stray data
    do_write(29'h100, 8'd0, 1'b0, {32{8'hA5}}, ones, 1'b0, '0);
    chk("wr0_first_word", (h2u_got.size() != 0) ? h2u_got[0] : '0, {1'b1, 247'b0, 8'h00} | 256'h100);
    chk("wr0_resp_err", resp_err, 0);

    // Four-beat write with full toggling every cycle
    do_write(29'h1234, 8'd3, 1'b1, '0, ones, 1'b0, '0);
    chk("wr3_resp_err", resp_err, 0);

    // Eight-beat read, throttled, one extra word left behind
    do_read(29'h3F_FFFF, 8'd7, 1);
    repeat (3) step();
    chk("idle_no_pop", u2h_q.size(), 1);
    u2h_q.delete();
    u2h_sync();

    // Random-length read
    do_read(29'($urandom), 8'($urandom_range(1, 20)), 0);

    // Bad completion word sets the sticky error
    do_write(29'h55, 8'd0, 1'b0, '0, 256'h1, 1'b0, '0);
    chk("bad_ack_resp_err", resp_err, 1);

    // Back-to-back: read held pending, accepted on the wr_done cycle
    do_write(29'h200, 8'd1, 1'b0, '0, ones, 1'b1, 29'h300);
    rd_phase(8'd0, 0, 1'b0);
    chk("resp_err_sticky", resp_err, 1);

    // Reset in the middle of a 4-beat write
    accept(1'b1, 29'h77, 8'd3);
    wdata_valid = 1'b1;
    b = 0;
    for (int i = 0; i < 50 && b < 2; i++) begin
      wdata = rand256();
      step();
      if (wfire) b++;
    end
    chk("mid_beats", b, 2);
    chk("mid_busy", busy, 1);
    hzz_rst_n = 1'b0;
    @(posedge hzz_clk);
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_h2u_wen", h2u_wen, 0);
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_wdata_ready", wdata_ready, 0);
    chk("mrst_resp_err", resp_err, 0);
    @(negedge hzz_clk);
    wdata_valid = 1'b0;
    h2u_got.delete();
    u2h_q.delete();
    u2h_sync();
    hzz_rst_n = 1'b1;
    step();
    do_write(29'hABCDE, 8'd0, 1'b0, '0, ones, 1'b0, '0);
    chk("post_rst_resp_err", resp_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
